// File: rtl/ru_mem_req.sv
// ru_mem_req: initiator side of the data-memory port.
// Turns core load/store requests into accesses on a word-addressed,
// word-written RAM. Loads are extended, word stores go straight through,
// and sub-word stores are done as a read-modify-write. The core is stalled
// until each access completes.
module ru_mem_req #(
    parameter int unsigned MEM_WORDS = 52
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RMW_RD,
        S_RMW_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_buf;

    logic        req_any;
    logic        req_bad;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    // A store wins over a load when both are raised.
    assign req_any = req_read | req_write;

    // Reject illegal size codes, misalignment and out-of-range word indices.
    always_comb begin
        req_bad = 1'b0;
        if (req_write) begin
            case (funct3)
                3'b000:  req_bad = 1'b0;
                3'b001:  req_bad = cpu_addr[0];
                3'b010:  req_bad = |cpu_addr[1:0];
                default: req_bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b100: req_bad = 1'b0;
                3'b001, 3'b101: req_bad = cpu_addr[0];
                3'b010:         req_bad = |cpu_addr[1:0];
                default:        req_bad = 1'b1;
            endcase
        end
        if ({2'b00, cpu_addr[31:2]} >= MEM_WORDS) begin
            req_bad = 1'b1;
        end
    end

    // State register; reset drops any in-flight access immediately.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and control outputs; ram_we is gated by ram_busy.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        ram_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_any) begin
                    stall = 1'b1;
                    if (req_bad) begin
                        state_next = S_ERR;
                    end else if (req_write) begin
                        state_next = (funct3 == 3'b010) ? S_WRITE : S_RMW_RD;
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
            S_READ: begin
                stall = 1'b1;
                if (!ram_busy) begin
                    state_next = S_DONE;
                end
            end
            S_WRITE: begin
                stall  = 1'b1;
                ram_we = !ram_busy;
                if (!ram_busy) begin
                    state_next = S_DONE;
                end
            end
            S_RMW_RD: begin
                stall = 1'b1;
                if (!ram_busy) begin
                    state_next = S_RMW_WR;
                end
            end
            S_RMW_WR: begin
                stall  = 1'b1;
                ram_we = !ram_busy;
                if (!ram_busy) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_ERR: begin
                done       = 1'b1;
                err        = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request capture, load result register and merge buffer.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            ram_addr  <= '0;
            off_q     <= '0;
            funct3_q  <= '0;
            wdata_q   <= '0;
            merge_buf <= '0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        ram_addr <= {cpu_addr[31:2], 2'b00};
                        off_q    <= cpu_addr[1:0];
                        funct3_q <= funct3;
                        wdata_q  <= cpu_wdata;
                    end
                end
                S_READ: begin
                    if (!ram_busy) begin
                        cpu_rdata <= load_val;
                    end
                end
                S_RMW_RD: begin
                    if (!ram_busy) begin
                        merge_buf <= ram_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Lane select and sign/zero extension of the RAM word for loads.
    always_comb begin
        case (off_q)
            2'd0:    rd_byte = ram_rdata[7:0];
            2'd1:    rd_byte = ram_rdata[15:8];
            2'd2:    rd_byte = ram_rdata[23:16];
            default: rd_byte = ram_rdata[31:24];
        endcase
        rd_half = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'b0, rd_byte};
            3'b101:  load_val = {16'b0, rd_half};
            default: load_val = ram_rdata;
        endcase
    end

    // Replace the addressed byte (SB) or half (SH) in the buffered word.
    always_comb begin
        merged = merge_buf;
        if (funct3_q[0]) begin
            if (off_q[1]) begin
                merged[31:16] = wdata_q[15:0];
            end else begin
                merged[15:0] = wdata_q[15:0];
            end
        end else begin
            case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    assign ram_wdata = (state == S_RMW_WR) ? merged : wdata_q;

endmodule

// File: tb/tb_ru_mem_req.sv
// tb_ru_mem_req: directed plus random load/store traffic against a RAM
// model, checked against a byte-level reference of memory and load results.
module tb_ru_mem_req;

    localparam int unsigned WORDS = 52;

    logic        clk;
    logic        nRst;
    logic        req_read;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        done;
    logic        err;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_busy;

    logic [31:0] mem     [WORDS];
    logic [31:0] exp_mem [WORDS];
    logic [31:0] exp_rdata;

    int n_cmp;
    int n_fail;

    ru_mem_req #(.MEM_WORDS(WORDS)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .req_read  (req_read),
        .req_write (req_write),
        .funct3    (funct3),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_busy  (ram_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: combinational read, write on the clock edge when enabled.
    assign ram_rdata = (ram_addr < WORDS * 4) ? mem[ram_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (ram_we && ram_addr < WORDS * 4) mem[ram_addr[7:2]] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: byte-addressed memory semantics and expected cycle counts.
    function automatic void ref_model(input bit wr, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      input int nb1, input int nb2,
                                      output bit e, output int lat, output int wes);
        int unsigned size;
        int unsigned off;
        int unsigned idx;
        bit legal;
        logic [63:0] m;
        logic [63:0] v;
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e = !legal;
        if (!e) e = ((a % size) != 0) || ((a / 4) >= WORDS);
        wes = 0;
        if (e) begin
            lat = 1;
            return;
        end
        off = a % 4;
        idx = a / 4;
        m   = (64'h1 << (8 * size)) - 64'h1;
        if (!wr) begin
            v = ({32'h0, exp_mem[idx]} >> (8 * off)) & m;
            if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~m;
            exp_rdata = v[31:0];
            lat = 2 + nb1;
        end else begin
            m = m << (8 * off);
            v = ({32'h0, exp_mem[idx]} & ~m) | (({32'h0, wd} << (8 * off)) & m);
            exp_mem[idx] = v[31:0];
            lat = (size == 4) ? 2 + nb1 : 3 + nb1 + nb2;
            wes = 1;
        end
    endfunction

    // Issue one request, hold it until done, and check the outcome.
    task automatic run_req(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int nb1, input int nb2,
                           output int lat_obs);
        bit e_exp;
        bit rmw;
        bit got_done;
        logic err_obs;
        int lat_exp;
        int we_exp;
        int we_obs;
        int cyc;
        int unsigned tgt;
        logic [31:0] wa;
        ref_model(wr, f3, a, wd, nb1, nb2, e_exp, lat_exp, we_exp);
        rmw = wr && (f3 == 3'b000 || f3 == 3'b001) && !e_exp;
        wa  = {a[31:2], 2'b00};
        req_write = wr;
        req_read  = !wr;
        funct3    = f3;
        cpu_addr  = a;
        cpu_wdata = wd;
        ram_busy  = 1'b0;
        cyc = 0;
        got_done = 1'b0;
        we_obs = 0;
        lat_obs = -1;
        err_obs = 1'b0;
        while (!got_done && cyc < 60) begin
            @(negedge clk);
            if (ram_we) we_obs++;
            if (cyc == 0) chk("stall_req", 32'(stall), 32'd1);
            if (done) begin
                got_done = 1'b1;
                lat_obs = cyc;
                err_obs = err;
                chk("stall_done", 32'(stall), 32'd0);
            end else if (cyc > 0) begin
                chk("stall_busy", 32'(stall), 32'd1);
                if (!e_exp) chk("ram_addr_hold", ram_addr, wa);
            end
            @(posedge clk);
            #1;
            cyc++;
            ram_busy = (cyc >= 1 && cyc <= nb1) || (rmw && cyc >= nb1 + 2 && cyc <= nb1 + 1 + nb2);
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
        end
        req_read  = 1'b0;
        req_write = 1'b0;
        ram_busy  = 1'b0;
        chk("latency", lat_obs, lat_exp);
        chk("err", 32'(err_obs), 32'(e_exp));
        chk("we_count", we_obs, we_exp);
        chk("cpu_rdata", cpu_rdata, exp_rdata);
        tgt = (e_exp) ? 0 : a / 4;
        for (int i = 0; i < WORDS; i++) begin
            if (mem[i] !== exp_mem[i] || i == tgt) chk("mem_word", mem[i], exp_mem[i]);
        end
    endtask

    initial begin
        int lat;
        n_cmp = 0;
        n_fail = 0;
        exp_rdata = '0;
        nRst = 1'b1;
        req_read = 1'b0;
        req_write = 1'b0;
        funct3 = '0;
        cpu_addr = '0;
        cpu_wdata = '0;
        ram_busy = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = $urandom;
            exp_mem[i] = mem[i];
        end
        mem[3] = 32'h80FF1234;
        exp_mem[3] = 32'h80FF1234;

        #1 nRst = 1'b0;
        #1;
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_stall_idle", 32'(stall), 32'd0);
        req_read = 1'b1;
        #1 chk("rst_stall_req", 32'(stall), 32'd1);
        req_read = 1'b0;
        @(posedge clk);
        #1 nRst = 1'b1;
        @(posedge clk);
        #1;

        // Loads from word 3.
        run_req(1'b0, 3'b010, 32'h0C, 32'h0, 0, 0, lat);
        chk("lw_lat", lat, 2);
        chk("lw_val", cpu_rdata, 32'h80FF1234);
        run_req(1'b0, 3'b000, 32'h0F, 32'h0, 0, 0, lat);
        chk("lb_val", cpu_rdata, 32'hFFFFFF80);
        run_req(1'b0, 3'b100, 32'h0F, 32'h0, 0, 0, lat);
        chk("lbu_val", cpu_rdata, 32'h00000080);
        run_req(1'b0, 3'b001, 32'h0E, 32'h0, 0, 0, lat);
        chk("lh_val", cpu_rdata, 32'hFFFF80FF);
        run_req(1'b0, 3'b101, 32'h0C, 32'h0, 0, 0, lat);
        chk("lhu_val", cpu_rdata, 32'h00001234);

        // Stores.
        run_req(1'b1, 3'b000, 32'h0D, 32'h000000AB, 0, 0, lat);
        chk("sb_lat", lat, 3);
        chk("sb_word", mem[3], 32'h80FFAB34);
        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, lat);
        chk("sw_lat", lat, 2);
        chk("sw_word", mem[4], 32'hDEADBEEF);

        // Error cases leave cpu_rdata at the last load result.
        run_req(1'b0, 3'b010, 32'h0E, 32'h0, 0, 0, lat);
        chk("err_lw_mis_lat", lat, 1);
        run_req(1'b1, 3'b001, 32'h0D, 32'h1234, 0, 0, lat);
        chk("err_sh_mis_lat", lat, 1);
        run_req(1'b0, 3'b011, 32'h0C, 32'h0, 0, 0, lat);
        chk("err_f3_lat", lat, 1);
        run_req(1'b0, 3'b010, 32'hD0, 32'h0, 0, 0, lat);
        chk("err_range_lat", lat, 1);
        chk("err_rdata_kept", cpu_rdata, 32'h00001234);
        run_req(1'b0, 3'b010, 32'hCC, 32'h0, 0, 0, lat);
        chk("last_word_lat", lat, 2);

        // Busy stretching.
        run_req(1'b0, 3'b010, 32'h0C, 32'h0, 3, 0, lat);
        chk("busy_rd_lat", lat, 5);
        chk("busy_rd_val", cpu_rdata, 32'h80FFAB34);
        run_req(1'b1, 3'b000, 32'h0C, 32'h11, 0, 3, lat);
        chk("busy_rmw_lat", lat, 6);
        chk("busy_rmw_word", mem[3], 32'h80FFAB11);

        // Random traffic.
        for (int t = 0; t < 200; t++) begin
            bit wr;
            logic [2:0] f3;
            logic [31:0] a;
            logic [31:0] wd;
            int nb1;
            int nb2;
            int r;
            int lf;
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (wr) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                lf = $urandom_range(0, 4);
                f3 = (lf < 3) ? 3'(lf) : 3'(lf + 1);
            end
            r = $urandom_range(0, 9);
            if (r == 0) a = $urandom;
            else if (r == 1) a = $urandom_range(WORDS * 4, WORDS * 4 + 31);
            else a = $urandom_range(0, WORDS * 4 - 1);
            if (r > 3) begin
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
            end
            wd  = $urandom;
            nb1 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            nb2 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            run_req(wr, f3, a, wd, nb1, nb2, lat);
        end

        // Reset while a sub-word store waits on a busy RAM.
        req_write = 1'b1;
        funct3 = 3'b000;
        cpu_addr = 32'h0D;
        cpu_wdata = 32'h55;
        ram_busy = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 ram_busy = 1'b1;
        #1 chk("rmw_we_busy", 32'(ram_we), 32'd0);
        chk("rmw_stall_busy", 32'(stall), 32'd1);
        #1 nRst = 1'b0;
        #1;
        chk("mid_rst_we", 32'(ram_we), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_rdata", cpu_rdata, 32'h0);
        chk("mid_rst_addr", ram_addr, 32'h0);
        chk("mid_rst_wdata", ram_wdata, 32'h0);
        chk("mid_rst_stall_req", 32'(stall), 32'd1);
        ram_busy = 1'b0;
        #1 chk("mid_rst_we_free", 32'(ram_we), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 chk("mid_rst_we_later", 32'(ram_we), 32'd0);
        chk("mid_rst_word", mem[3], exp_mem[3]);
        req_write = 1'b0;
        #1 chk("mid_rst_stall_idle", 32'(stall), 32'd0);
        nRst = 1'b1;
        exp_rdata = '0;
        @(posedge clk);
        #1;
        run_req(1'b0, 3'b010, 32'h0C, 32'h0, 0, 0, lat);
        chk("post_rst_lat", lat, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
